serial_sub: RTL and testbench
=============================

// Module: serial_sub
// PURPOSE
//  Bit-serial ripple-borrow subtractor: the inverse operation of our parallel ripple-carry adder.
//  Latches two unsigned WIDTH-bit operands and computes d = a - b, one bit per clock, LSB first.
//  Uses a single full-subtractor cell and a registered borrow.
//  Sits behind a valid/ready input port and a valid/ready result port in the tt_um datapath.
// PARAMETERS
//  WIDTH  6  operand width in bits; WIDTH >= 2
// PORTS
//  clk        in   1        system clock, all logic rising-edge
//  rst_n      in   1        synchronous active-low reset, sampled on rising clk
//  in_valid   in   1        operands a/b valid
//  in_ready   out  1        block can accept operands
//  a          in   WIDTH    minuend, unsigned
//  b          in   WIDTH    subtrahend, unsigned
//  out_valid  out  1        result d valid
//  out_ready  in   1        consumer accepts result
//  d          out  WIDTH+1  {borrow, difference}; equals (a - b) mod 2^(WIDTH+1)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE, in_ready=0 during reset, out_valid=0, d=0,
//    borrow=0, bit counter=0. Reset mid-operation aborts the computation; no result is emitted.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: in_ready=1. in_valid&&in_ready latches a,b into shift regs; borrow:=0, cnt:=0; go RUN.
//    RUN:  in_ready=0. Each cycle: diff = a0^b0^bw, bw' = (~a0&b0)|(~(a0^b0)&bw); diff is shifted
//          into d[WIDTH-1] from the top (LSB ends at d[0]); a,b shift right; cnt++.
//          After WIDTH RUN cycles (cnt==WIDTH-1 on the last), d[WIDTH]:=final borrow; go DONE.
//    DONE: out_valid=1, d stable. out_valid&&out_ready -> IDLE, out_valid:=0 on the next edge.
//  - Latency: accept edge to first out_valid cycle = WIDTH+1 clocks. Throughput: 1 op per
//    WIDTH+2 clocks with out_ready tied high.
//  - in_ready is combinational from state only (IDLE). Never accepts while busy.
//  - out_ready low in DONE holds d and out_valid indefinitely.
//  - d is unchanged outside RUN; d is not cleared on accept, only overwritten bit by bit.
//  - a == b gives d = 0; a=0,b=max gives d = 2^(WIDTH+1) - (2^WIDTH - 1).
// CONFIGURATION
//  - SERIAL_SUB_SAT_EN defined: saturating mode. When the final borrow is 1, the DONE entry
//    writes d = 0 (all WIDTH+1 bits) instead of the wrapped difference. Latency is unchanged.
//  - Not defined: wrapping mode as described above; d[WIDTH] carries the borrow.
// STRUCTURE
//  - serial_sub_pkg: typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} serial_sub_state_t;
//    localparam SERIAL_SUB_WIDTH_DEFAULT = 6.
//  - Sub-module serial_sub_fullsubtractor (a, b, bw_in -> d, bw_out), purely combinational.
//    It is instantiated once, with the borrow register closing the loop.
//  - Counter width $clog2(WIDTH). FORMAL block: on the out_valid rise, assert that d matches
//    the latched operands.
//      wrap mode: d == ({1'b0,a_q} - {1'b0,b_q})
//      sat mode:  d == ((a_q < b_q) ? 0 : a_q - b_q)
// TESTING (WIDTH=6)
//  1. a=45, b=17, out_ready=1 -> out_valid 7 clks after accept, d=7'd28, in_ready back after handshake.
//  2. a=5, b=9 -> d=7'd124 (borrow=1). With SERIAL_SUB_SAT_EN -> d=7'd0.
//  3. a=63, b=63 and a=0, b=0 -> d=0 both; a=0, b=63 -> d=7'd65.
//  4. Backpressure: out_ready=0 for 10 clks in DONE -> out_valid, d stable; in_valid=1 ignored (in_ready=0).
//  5. Reset mid-RUN (cnt=3) -> next cycle IDLE, out_valid=0, d=0; new op a=20, b=7 -> d=7'd13.
//  6. Back-to-back: in_valid and out_ready held high, 100 random ops -> results in order, one per 8 clks.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } serial_sub_state_t;

    localparam int SERIAL_SUB_WIDTH_DEFAULT = 6;

endpackage

// File: rtl/serial_sub_fullsubtractor.sv
// One-bit full subtractor cell: d = a - b - bw_in, with borrow out.
module serial_sub_fullsubtractor (
    input  logic a,
    input  logic b,
    input  logic bw_in,
    output logic d,
    output logic bw_out
);

    assign d      = a ^ b ^ bw_in;
    assign bw_out = (~a & b) | (~(a ^ b) & bw_in);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial ripple-borrow subtractor, d = a - b, LSB first, one bit per clock.
// Define SERIAL_SUB_SAT_EN for saturating mode (negative results clamp to zero).
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   d
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    serial_sub_state_t state;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [CW-1:0]     cnt;
    logic              bw;
    logic              diff;
    logic              bw_out;

    // Single cell; the borrow register closes the ripple loop across cycles.
    serial_sub_fullsubtractor u_cell (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .bw_in  (bw),
        .d      (diff),
        .bw_out (bw_out)
    );

    // Held low through reset so no operands are taken while rst_n is asserted.
    assign in_ready = rst_n && (state == S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the later d write in RUN legally overrides the earlier one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            d         <= '0;
            bw        <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        bw    <= 1'b0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh           <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh           <= {1'b0, b_sh[WIDTH-1:1]};
                    bw             <= bw_out;
                    cnt            <= cnt + 1'b1;
                    d[WIDTH-1:0]   <= {diff, d[WIDTH-1:1]};
                    if (cnt == CNT_LAST) begin
                        d[WIDTH]  <= bw_out;
`ifdef SERIAL_SUB_SAT_EN
                        if (bw_out) begin
                            d <= '0;
                        end
`endif
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FORMAL
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             out_valid_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            out_valid_d <= 1'b0;
        end else begin
            out_valid_d <= out_valid;
            if (in_valid && in_ready) begin
                a_q <= a;
                b_q <= b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && out_valid && !out_valid_d) begin
`ifdef SERIAL_SUB_SAT_EN
            assert (d == ((a_q < b_q) ? '0 : {1'b0, a_q - b_q}));
`else
            assert (d == ({1'b0, a_q} - {1'b0, b_q}));
`endif
        end
    end
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub at WIDTH=6 (wrap or SERIAL_SUB_SAT_EN mode).
module tb_serial_sub;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   d;

    int total = 0;
    int bad   = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_d(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'(x) - int'(y);
`ifdef SERIAL_SUB_SAT_EN
        if (r < 0) return '0;
`endif
        if (r < 0) r = r + 128;
        return (W+1)'(r);
    endfunction

    // Presents one operand pair from IDLE and waits for out_valid (bounded).
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic [W:0] dg, output int lat, output logic busy_rdy);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        busy_rdy = in_ready;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        dg = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if (d !== 7'd0) begin bad++; $display("FAIL reset_d got=%0d want=0", d); end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic;
        logic [W:0] dg;
        int lat;
        logic br;
        out_ready = 1'b1;
        run_op(6'd45, 6'd17, dg, lat, br);
        total++;
        if (br !== 1'b0) begin bad++; $display("FAIL basic_busy_in_ready got=%b want=0", br); end
        total++;
        if (lat != 7) begin bad++; $display("FAIL basic_latency got=%0d want=7", lat); end
        total++;
        if (dg !== 7'd28) begin bad++; $display("FAIL basic_d got=%0d want=28", dg); end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_out_valid_drop got=%b want=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_back got=%b want=1", in_ready); end
    endtask

    task automatic test_borrow;
        logic [W:0] dg;
        logic [W:0] want;
        int lat;
        logic br;
`ifdef SERIAL_SUB_SAT_EN
        want = 7'd0;
`else
        want = 7'd124;
`endif
        run_op(6'd5, 6'd9, dg, lat, br);
        total++;
        if (dg !== want) begin bad++; $display("FAIL borrow_d got=%0d want=%0d", dg, want); end
        total++;
        if (lat != 7) begin bad++; $display("FAIL borrow_latency got=%0d want=7", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_extremes;
        logic [W-1:0] va [3] = '{6'd63, 6'd0, 6'd0};
        logic [W-1:0] vb [3] = '{6'd63, 6'd0, 6'd63};
        logic [W:0]   vd [3];
        logic [W:0]   dg;
        int lat;
        logic br;
        vd[0] = 7'd0;
        vd[1] = 7'd0;
`ifdef SERIAL_SUB_SAT_EN
        vd[2] = 7'd0;
`else
        vd[2] = 7'd65;
`endif
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], dg, lat, br);
            total++;
            if (dg !== vd[i]) begin
                bad++;
                $display("FAIL extreme_d a=%0d b=%0d got=%0d want=%0d", va[i], vb[i], dg, vd[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic [W:0] dg;
        int lat;
        logic br;
        out_ready = 1'b0;
        run_op(6'd40, 6'd10, dg, lat, br);
        total++;
        if (dg !== 7'd30) begin bad++; $display("FAIL bp_d got=%0d want=30", dg); end
        a = 6'd1;
        b = 6'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || d !== 7'd30 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got ov=%b d=%0d ir=%b want ov=1 d=30 ir=0",
                         i, out_valid, d, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [W:0] dg;
        int lat;
        logic br;
        a = 6'd50;
        b = 6'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || d !== 7'd0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state got ov=%b d=%0d ir=%b want ov=0 d=0 ir=0", out_valid, d, in_ready);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle got ir=%b want=1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_result cyc=%0d got ov=%b want=0", i, out_valid); end
        end
        run_op(6'd20, 6'd7, dg, lat, br);
        total++;
        if (dg !== 7'd13) begin bad++; $display("FAIL midrst_new_op got=%0d want=13", dg); end
        total++;
        if (lat != 7) begin bad++; $display("FAIL midrst_latency got=%0d want=7", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [W:0] exp_q [$];
        int issued = 0;
        int results = 0;
        int last_cyc = -1;
        logic pre_acc;
        logic [W:0] want;
        out_ready = 1'b1;
        a = W'($urandom_range(0, 63));
        b = W'($urandom_range(0, 63));
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 1000 && results < 100; cyc++) begin
            pre_acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (pre_acc) begin
                exp_q.push_back(ref_d(a, b));
                issued++;
                a = W'($urandom_range(0, 63));
                b = W'($urandom_range(0, 63));
                if (issued == 100) in_valid = 1'b0;
            end
            if (out_valid) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                total++;
                if (d !== want) begin
                    bad++;
                    $display("FAIL b2b_d idx=%0d got=%0d want=%0d", results, d, want);
                end
                if (last_cyc >= 0) begin
                    total++;
                    if (cyc - last_cyc != 8) begin
                        bad++;
                        $display("FAIL b2b_spacing idx=%0d got=%0d want=8", results, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                results++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (results != 100) begin bad++; $display("FAIL b2b_count got=%0d want=100", results); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_borrow;
        test_extremes;
        test_backpressure;
        test_reset_mid_run;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
